// File: rtl/ysyx_25040111_mem_pkg.sv
// ysyx_25040111_mem_pkg: shared FSM state and access-size codes for the memory crossbar
package ysyx_25040111_mem_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
endpackage

// File: rtl/ysyx_25040111_rr_pick.sv
// ysyx_25040111_rr_pick: combinational winner select, fixed priority or round-robin from ptr
module ysyx_25040111_rr_pick #(
  parameter int NM = 2
) (
  input  logic [NM-1:0]         req,
  input  logic [$clog2(NM)-1:0] ptr,
  input  logic                  rr,
  output logic [$clog2(NM)-1:0] idx,
  output logic [NM-1:0]         onehot
);
  localparam int IW = $clog2(NM);
  logic [NM-1:0] ge;
  logic [NM-1:0] hi;
  logic [NM-1:0] pick;
  assign ge = ~((NM'(1) << (rr ? ptr : '0)) - NM'(1));
  assign hi = req & ge;
  assign pick = |hi ? hi : req;
  assign onehot = pick & (~pick + NM'(1));
  for (genvar i = 0; i < NM; i++) begin : g_enc
    logic [IW-1:0] acc;
    if (i == 0) begin : g_z
      assign acc = '0;
    end else begin : g_o
      assign acc = g_enc[i-1].acc | (onehot[i] ? IW'(i) : '0);
    end
  end
  assign idx = g_enc[NM-1].acc;
endmodule

// File: rtl/ysyx_25040111_mem_xbar.sv
// ysyx_25040111_mem_xbar: N-master to single-port memory arbiter holding grant for a whole transaction
module ysyx_25040111_mem_xbar
  import ysyx_25040111_mem_pkg::*;
#(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8,
  parameter int RR = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NM-1:0]    m_valid,
  input  logic [NM-1:0]    m_write,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  input  logic [NM*2-1:0]  m_mask,
  input  logic [NM-1:0]    m_rsign,
  input  logic [NM-1:0]    m_burst,
  input  logic [NM*LW-1:0] m_rlen,
  output logic [NM-1:0]    m_ready,
  output logic [DW-1:0]    m_rdata,
  output logic [NM-1:0]    m_grant,
  output logic             s_rvalid,
  input  logic             s_rready,
  input  logic [DW-1:0]    s_rdata,
  output logic [AW-1:0]    s_raddr,
  output logic [LW-1:0]    s_rlen,
  output logic             s_burst,
  output logic             s_rsign,
  output logic [1:0]       s_rmask,
  output logic             s_wvalid,
  input  logic             s_wready,
  output logic [AW-1:0]    s_waddr,
  output logic [DW-1:0]    s_wdata,
  output logic [1:0]       s_wmask
);
  localparam int IW = $clog2(NM);
  state_t        state;
  logic [IW-1:0] w;
  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt;
  logic [IW-1:0] win;
  logic [NM-1:0] win_oh;
  logic [NM-1:0] grant_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [1:0]    mask_r;
  logic          rsign_r;
  logic          burst_r;
  logic [LW-1:0] rlen_r;
  logic [LW-1:0] beats;
  logic          rd_fire;
  logic          wr_fire;
  logic          done;
  logic [AW-1:0] addr_a  [NM];
  logic [DW-1:0] wdata_a [NM];
  logic [1:0]    mask_a  [NM];
  logic [LW-1:0] rlen_a  [NM];
  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign addr_a[i]  = m_addr[i*AW +: AW];
    assign wdata_a[i] = m_wdata[i*DW +: DW];
    assign mask_a[i]  = m_mask[i*2 +: 2];
    assign rlen_a[i]  = m_rlen[i*LW +: LW];
  end
  ysyx_25040111_rr_pick #(.NM(NM)) u_pick (
    .req    (m_valid),
    .ptr    (ptr),
    .rr     (RR != 0),
    .idx    (win),
    .onehot (win_oh)
  );
  assign rd_fire  = state == RD && s_rready;
  assign wr_fire  = state == WR && s_wready;
  assign done     = wr_fire || (rd_fire && beats == '0);
  assign nxt      = (w == IW'(NM - 1)) ? '0 : w + IW'(1);
  assign s_rvalid = state == RD;
  assign s_wvalid = state == WR;
  assign s_raddr  = addr_r;
  assign s_waddr  = addr_r;
  assign s_wdata  = wdata_r;
  assign s_rmask  = mask_r;
  assign s_wmask  = mask_r;
  assign s_rlen   = rlen_r;
  assign s_burst  = burst_r;
  assign s_rsign  = rsign_r;
  assign m_grant  = state != IDLE ? grant_r : '0;
  assign m_ready  = (rd_fire || wr_fire) ? grant_r : '0;
  assign m_rdata  = rd_fire ? s_rdata : '0;
  // arbitrate in IDLE, latch the winner's request, then count beats until the transaction completes
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      w       <= '0;
      grant_r <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      mask_r  <= SZ_B;
      rsign_r <= 1'b0;
      burst_r <= 1'b0;
      rlen_r  <= '0;
      beats   <= '0;
    end else if (state == IDLE) begin
      if (|m_valid) begin
        w       <= win;
        grant_r <= win_oh;
        addr_r  <= addr_a[win];
        wdata_r <= wdata_a[win];
        mask_r  <= mask_a[win];
        rsign_r <= m_rsign[win];
        burst_r <= m_burst[win];
        rlen_r  <= m_burst[win] ? rlen_a[win] : '0;
        beats   <= m_burst[win] ? rlen_a[win] : '0;
        state   <= m_write[win] ? WR : RD;
      end
    end else begin
      if (rd_fire && beats != '0) beats <= beats - LW'(1);
      if (done) begin
        state <= IDLE;
        if (RR != 0) ptr <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25040111_mem_xbar.sv
// tb_ysyx_25040111_mem_xbar: vector table, directed sequences and randomized model check of the crossbar
module tb_ysyx_25040111_mem_xbar;
  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic [NM-1:0]    r_valid = '0, f_valid = '0;
  logic [NM-1:0]    m_write = '0, m_rsign = '0, m_burst = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdata = '0;
  logic [NM*2-1:0]  m_mask = '0;
  logic [NM*LW-1:0] m_rlen = '0;
  logic             r_rready = 1'b0, r_wready = 1'b0, f_rready = 1'b0, f_wready = 1'b0;
  logic [DW-1:0]    s_rdata = '0;
  logic [NM-1:0]    r_ready, r_grant, f_ready, f_grant;
  logic [DW-1:0]    r_rdata, f_rdata, r_wdata, f_wdata;
  logic             r_rvalid, r_burst, r_rsign, r_wvalid, f_rvalid, f_burst, f_rsign, f_wvalid;
  logic [AW-1:0]    r_raddr, r_waddr, f_raddr, f_waddr;
  logic [LW-1:0]    r_rlen, f_rlen;
  logic [1:0]       r_rmask, r_wmask, f_rmask, f_wmask;
  int checks = 0;
  int errors = 0;
  ysyx_25040111_mem_xbar #(.NM(NM), .AW(AW), .DW(DW), .LW(LW), .RR(1)) u_rr (
    .clock(clock), .reset(reset), .m_valid(r_valid), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_mask(m_mask), .m_rsign(m_rsign), .m_burst(m_burst), .m_rlen(m_rlen),
    .m_ready(r_ready), .m_rdata(r_rdata), .m_grant(r_grant),
    .s_rvalid(r_rvalid), .s_rready(r_rready), .s_rdata(s_rdata), .s_raddr(r_raddr), .s_rlen(r_rlen),
    .s_burst(r_burst), .s_rsign(r_rsign), .s_rmask(r_rmask),
    .s_wvalid(r_wvalid), .s_wready(r_wready), .s_waddr(r_waddr), .s_wdata(r_wdata), .s_wmask(r_wmask)
  );
  ysyx_25040111_mem_xbar #(.NM(NM), .AW(AW), .DW(DW), .LW(LW), .RR(0)) u_fp (
    .clock(clock), .reset(reset), .m_valid(f_valid), .m_write(m_write), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_mask(m_mask), .m_rsign(m_rsign), .m_burst(m_burst), .m_rlen(m_rlen),
    .m_ready(f_ready), .m_rdata(f_rdata), .m_grant(f_grant),
    .s_rvalid(f_rvalid), .s_rready(f_rready), .s_rdata(s_rdata), .s_raddr(f_raddr), .s_rlen(f_rlen),
    .s_burst(f_burst), .s_rsign(f_rsign), .s_rmask(f_rmask),
    .s_wvalid(f_wvalid), .s_wready(f_wready), .s_waddr(f_waddr), .s_wdata(f_wdata), .s_wmask(f_wmask)
  );
  typedef struct {
    logic [2:0]  valid;
    logic        rready;
    logic [31:0] rdata;
    logic [2:0]  grant;
    logic [2:0]  ready;
    logic [31:0] mrdata;
    logic        rvalid;
    logic [31:0] raddr;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic set_m(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] mask, input logic sign, input logic burst, input logic [7:0] rlen);
    m_write[i] = wr;
    m_addr[i*AW +: AW] = addr;
    m_wdata[i*DW +: DW] = data;
    m_mask[i*2 +: 2] = mask;
    m_rsign[i] = sign;
    m_burst[i] = burst;
    m_rlen[i*LW +: LW] = rlen;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    r_valid = '0;
    f_valid = '0;
    r_rready = 1'b0;
    r_wready = 1'b0;
    f_rready = 1'b0;
    f_wready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_grant", {r_grant, f_grant}, 0);
    chk("rst_valid", {r_rvalid, r_wvalid, f_rvalid, f_wvalid}, 0);
    chk("rst_ready", {r_ready, f_ready}, 0);
    chk("rst_fields", {r_raddr, r_rlen, r_rmask, r_burst, r_rsign}, 0);
    reset = 1'b0;
  endtask
  initial begin
    int pulses, stalls;
    bit stalled, busy, ewr, fire;
    int o, n, mptr;
    logic [31:0] eaddr, edata;
    logic [1:0]  emask;
    logic        esign, eburst;
    logic [7:0]  erlen;
    logic [NM-1:0] done_m;
    tbl[0] = '{3'b101, 1'b1, 32'h11, 3'b000, 3'b000, 32'h0,  1'b0, 32'h0};
    tbl[1] = '{3'b101, 1'b1, 32'h22, 3'b001, 3'b001, 32'h22, 1'b1, 32'h100};
    tbl[2] = '{3'b100, 1'b1, 32'h33, 3'b000, 3'b000, 32'h0,  1'b0, 32'h0};
    tbl[3] = '{3'b100, 1'b0, 32'h44, 3'b100, 3'b000, 32'h0,  1'b1, 32'h300};
    tbl[4] = '{3'b100, 1'b1, 32'h55, 3'b100, 3'b100, 32'h55, 1'b1, 32'h300};
    tbl[5] = '{3'b000, 1'b1, 32'h66, 3'b000, 3'b000, 32'h0,  1'b0, 32'h0};
    do_reset();
    set_m(0, 1'b0, 32'h100, 0, 2'b10, 1'b0, 1'b0, 8'd5);
    set_m(1, 1'b0, 32'h200, 0, 2'b10, 1'b0, 1'b0, 8'd0);
    set_m(2, 1'b0, 32'h300, 0, 2'b10, 1'b0, 1'b0, 8'd7);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      f_valid = tbl[k].valid;
      f_rready = tbl[k].rready;
      s_rdata = tbl[k].rdata;
      #1;
      chk($sformatf("fp%0d_grant", k), f_grant, tbl[k].grant);
      chk($sformatf("fp%0d_ready", k), f_ready, tbl[k].ready);
      chk($sformatf("fp%0d_rdata", k), f_rdata, tbl[k].mrdata);
      chk($sformatf("fp%0d_rvalid", k), f_rvalid, tbl[k].rvalid);
      if (tbl[k].rvalid) begin
        chk($sformatf("fp%0d_raddr", k), f_raddr, tbl[k].raddr);
        chk($sformatf("fp%0d_rlen", k), f_rlen, 0);
      end
    end
    f_valid = '0;
    r_rready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c == 0) r_valid = 3'b111;
      #1;
      chk($sformatf("rr%0d_grant", c), r_grant, (c % 2 == 1) ? (3'b001 << ((c / 2) % 3)) : 3'b000);
      chk($sformatf("rr%0d_ready", c), r_ready, (c % 2 == 1) ? (3'b001 << ((c / 2) % 3)) : 3'b000);
    end
    @(negedge clock);
    r_valid = '0;
    #1;
    chk("rr_end_grant", r_grant, 0);
    set_m(1, 1'b0, 32'h3000_0000, 0, 2'b10, 1'b0, 1'b1, 8'd3);
    pulses = 0;
    stalled = 0;
    for (int c = 0; c < 20 && pulses < 4; c++) begin
      @(negedge clock);
      if (c == 0) r_valid = 3'b010;
      r_rready = !(pulses == 2 && !stalled);
      s_rdata = 32'hA0 + pulses;
      if (r_grant[1]) m_addr[AW +: AW] = $urandom;
      #1;
      if (r_rvalid) begin
        chk("b_raddr", r_raddr, 32'h3000_0000);
        chk("b_rlen", r_rlen, 3);
        chk("b_burst", r_burst, 1);
      end
      if (!r_rready) begin
        stalled = 1;
        chk("b_stall_ready", r_ready, 0);
      end
      if (r_ready != 0) begin
        chk("b_owner", r_ready, 3'b010);
        chk("b_rdata", r_rdata, 32'hA0 + pulses);
        pulses++;
      end
    end
    chk("b_pulses", pulses, 4);
    @(negedge clock);
    r_valid = '0;
    #1;
    chk("b_idle_grant", r_grant, 0);
    chk("b_idle_rvalid", r_rvalid, 0);
    set_m(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 8'd0);
    pulses = 0;
    stalls = 0;
    for (int c = 0; c < 20 && pulses == 0; c++) begin
      @(negedge clock);
      if (c == 0) r_valid = 3'b001;
      r_wready = stalls == 3;
      #1;
      chk("c_rvalid", r_rvalid, 0);
      if (r_wvalid) begin
        chk("c_waddr", r_waddr, 32'h8000_0010);
        chk("c_wdata", r_wdata, 32'hDEAD_BEEF);
        chk("c_wmask", r_wmask, 2'b10);
        if (!r_wready) stalls++;
      end
      if (r_ready != 0) begin
        chk("c_owner", r_ready, 3'b001);
        pulses++;
      end
    end
    chk("c_stalls", stalls, 3);
    chk("c_pulses", pulses, 1);
    @(negedge clock);
    r_valid = '0;
    r_wready = 1'b0;
    #1;
    chk("c_ready_once", r_ready, 0);
    chk("c_wvalid_off", r_wvalid, 0);
    set_m(2, 1'b0, 32'h5000_0000, 0, 2'b10, 1'b0, 1'b1, 8'd3);
    set_m(0, 1'b0, 32'h40, 0, 2'b10, 1'b0, 1'b0, 8'd0);
    pulses = 0;
    for (int c = 0; c < 10 && pulses < 2; c++) begin
      @(negedge clock);
      if (c == 0) r_valid = 3'b100;
      r_rready = 1'b1;
      #1;
      if (r_ready[2]) pulses++;
    end
    chk("d_pulses", pulses, 2);
    @(negedge clock);
    reset = 1'b1;
    r_rready = 1'b0;
    r_valid = 3'b101;
    @(negedge clock);
    reset = 1'b0;
    r_rready = 1'b1;
    #1;
    chk("d_grant", r_grant, 0);
    chk("d_rvalid", r_rvalid, 0);
    chk("d_ready", r_ready, 0);
    @(negedge clock);
    #1;
    chk("d_fresh_grant", r_grant, 3'b001);
    chk("d_fresh_ready", r_ready, 3'b001);
    @(negedge clock);
    r_valid = '0;
    do_reset();
    busy = 0;
    o = 0;
    n = 0;
    mptr = 0;
    ewr = 0;
    eaddr = '0;
    edata = '0;
    emask = '0;
    esign = 0;
    eburst = 0;
    erlen = '0;
    done_m = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      r_valid = r_valid & ~done_m;
      done_m = '0;
      for (int i = 0; i < NM; i++)
        if (!r_valid[i] && $urandom_range(3) == 0) begin
          set_m(i, 1'($urandom_range(1)), $urandom, $urandom, 2'($urandom_range(2)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(4)));
          r_valid[i] = 1'b1;
        end
      if (busy) begin
        m_addr[o*AW +: AW] = $urandom;
        m_wdata[o*DW +: DW] = $urandom;
        m_rlen[o*LW +: LW] = 8'($urandom);
      end
      r_rready = $urandom_range(3) != 0;
      r_wready = $urandom_range(3) != 0;
      s_rdata = $urandom;
      #1;
      fire = busy && (ewr ? r_wready : r_rready);
      chk("r_grant", r_grant, busy ? (3'b001 << o) : 3'b000);
      chk("r_rvalid", r_rvalid, busy && !ewr);
      chk("r_wvalid", r_wvalid, busy && ewr);
      chk("r_ready", r_ready, fire ? (3'b001 << o) : 3'b000);
      chk("r_rdata", r_rdata, (fire && !ewr) ? s_rdata : 32'h0);
      if (busy && !ewr) chk("r_rfields", {r_raddr, r_rlen, r_burst, r_rsign, r_rmask},
                            {eaddr, eburst ? erlen : 8'h0, eburst, esign, emask});
      if (busy && ewr) chk("r_wfields", {r_waddr, r_wdata, r_wmask}, {eaddr, edata, emask});
      if (busy) begin
        if (fire) begin
          if (ewr || n == 1) begin
            busy = 0;
            done_m[o] = 1'b1;
            mptr = (o + 1) % NM;
          end else n--;
        end
      end else if (r_valid != 0) begin
        for (int k = NM - 1; k >= 0; k--)
          if (r_valid[(mptr + k) % NM]) o = (mptr + k) % NM;
        busy = 1;
        ewr = m_write[o];
        eaddr = m_addr[o*AW +: AW];
        edata = m_wdata[o*DW +: DW];
        emask = m_mask[o*2 +: 2];
        esign = m_rsign[o];
        eburst = m_burst[o];
        erlen = m_rlen[o*LW +: LW];
        n = eburst ? int'(erlen) + 1 : 1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_25040111_mem_xbar.md
# ysyx_25040111_mem_xbar

Parametrised N-master to single-port memory arbiter, the next generation of the two-way fetch/EXU arbiter. It sits between the requestors (I-cache refill, LSU load/store, future D-cache or DMA) and the single LSU/AXI bridge port. It arbitrates with a selectable fixed-priority or round-robin policy. It latches the winner's request, so the granted master's fields are not re-sampled, and holds the grant until the whole transaction completes: either a single write or a read burst of `rlen+1` beats.

## Interface
Parameters:
- `NM`, 2: number of masters, 2..8.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `LW`, 8: burst length field width.
- `RR`, 1: arbitration policy. 1 = round-robin; 0 = fixed priority, master 0 highest.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `m_valid` in NM: per-master request.
- `m_write` in NM: 1 = write, 0 = read.
- `m_addr` in NM*AW: packed addresses, master i at `[i*AW +: AW]`.
- `m_wdata` in NM*DW: packed write data.
- `m_mask` in NM*2: size, 00=B, 01=H, 10=W.
- `m_rsign` in NM: sign-extend read.
- `m_burst` in NM: burst read enable.
- `m_rlen` in NM*LW: beats minus one.
- `m_ready` out NM: per-master beat/acceptance strobe.
- `m_rdata` out DW: read data, shared by all masters.
- `m_grant` out NM: one-hot current owner.
- `s_rvalid` out 1, `s_rready` in 1, `s_rdata` in DW, `s_raddr` out AW, `s_rlen` out LW, `s_burst` out 1, `s_rsign` out 1, `s_rmask` out 2: slave read channel.
- `s_wvalid` out 1, `s_wready` in 1, `s_waddr` out AW, `s_wdata` out DW, `s_wmask` out 2: slave write channel.

## Operation
- FSM states: IDLE, RD, WR.
- IDLE, any `m_valid`:
  - Pick winner `w`. RR=0: lowest index. RR=1: first valid index at or after `ptr`, wrapping modulo NM.
  - Latch `w` and its write/addr/wdata/mask/rsign/burst/rlen into registers.
  - Load `beats` with `rlen` if `burst`, else 0.
  - Go to WR if write, else RD.
- RD:
  - `s_rvalid`=1. `s_raddr`, `s_rlen`, `s_burst`, `s_rsign`, `s_rmask` come from the latched registers.
  - Each `s_rvalid & s_rready`: `m_ready[w]`=1 and `m_rdata`=`s_rdata` in the same cycle.
  - When `beats`==0, go to IDLE; otherwise decrement `beats`.
- WR:
  - `s_wvalid`=1 with the latched fields.
  - On `s_wready`: `m_ready[w]`=1, go to IDLE.
- RR pointer: on the transaction-completing beat, `ptr` <= (w+1) mod NM. `ptr` is unchanged in fixed mode.
- `m_grant` = one-hot of `w` in RD/WR; 0 in IDLE.
- `m_ready` = 0 for non-owners always. `m_rdata` = 0 when no read beat.
- Master protocol:
  - Hold `m_valid` high until the final `m_ready`.
  - Fields are sampled only at grant.
  - Dropping `m_valid` while granted is illegal and is not checked; the transaction completes regardless.
- A master whose `m_valid` is still high after completion is treated as a new request.

## Timing
- Reset values:
  - state IDLE, `ptr`=0, `beats`=0.
  - All `s_*valid`=0, `m_ready`=0, `m_grant`=0.
  - Latched fields 0.
- Grant latency: `m_valid` seen in IDLE at cycle t; `s_*valid` asserted at t+1. No combinational path from `m_*` to `s_*`.
- Completion to next grant: the cycle after the last beat is IDLE (arbitration); the next transaction drives the slave one cycle later. This gives a 1-cycle bubble between transactions.
- `s_rvalid`/`s_wvalid` stay high, with fields stable, until handshake.
- Read beats may be back-to-back; `m_ready` may be high on consecutive cycles.
- `rlen`=0 with `burst`=1 is a single beat. `burst`=0 ignores `rlen` and drives `s_rlen`=0.
- Reset mid-transaction: next cycle is IDLE with all outputs at reset values. No `m_ready` is issued for the aborted beat. The slave is reset by the same signal.

## Structure
- Shared package `ysyx_25040111_mem_pkg`:
  - FSM state enum (IDLE/RD/WR).
  - Size codes SZ_B/SZ_H/SZ_W.
- Sub-module `ysyx_25040111_rr_pick`:
  - Parametrised NM.
  - Inputs: request vector, `ptr`, `RR`.
  - Outputs: winner index and one-hot.
  - Purely combinational.
- The top holds the FSM, latches, beat counter and pointer.

## Test plan
- RR=0, NM=3, masters 0 and 2 read simultaneously → master 0 granted first; master 2 granted 2 cycles after master 0's last beat.
- RR=1, NM=3, all masters hold continuous single-beat reads, slave always ready → grant order 0,1,2,0,1,2, each 2 cycles apart.
- Master 1 burst read, `rlen`=3, addr 0x3000_0000, slave returns 0xA0..0xA3 with one stall cycle after beat 1 → exactly 4 `m_ready[1]` pulses carrying 0xA0..0xA3; `s_raddr` stable throughout; IDLE afterwards.
- Master 0 write 0x8000_0010 data 0xDEADBEEF mask 10, `s_wready` delayed 3 cycles → `s_wvalid` held 3 cycles with fields stable; `m_ready[0]` high one cycle; `s_rvalid`=0 throughout.
- Change `m_addr` of the granted master mid-burst → `s_raddr` keeps the latched value.
- Reset asserted after beat 2 of a 4-beat burst → next cycle `m_grant`=0, `s_rvalid`=0, `ptr`=0; a fresh request is granted to index 0 first.
